gost_byte_stream_ctrl: RTL and testbench
========================================

// Module: gost_byte_stream_ctrl
// PURPOSE
//   Byte-stream front/back end for criptografia_GOST. Packs 8 input bytes into a 64-bit block,
//   drives the core start/enc_dec/data/key inputs, waits for core ready, captures the 64-bit result
//   and serialises it out as 8 bytes. Sits between the byte-wide link and the GOST core (both sides).
// PARAMETERS
//   TIMEOUT_CYCLES  1023  max cycles spent in START+WAIT before the block is abandoned
//   TO_W            10    width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//   clock           in   1    single clock, all logic rising-edge
//   reset           in   1    asynchronous, active-low (0 = reset)
//   enc_dec_i       in   1    1 = encrypt, 0 = decrypt; latched with first byte of each block
//   key_i           in   256  key; latched with first byte of each block
//   in_byte_i       in   8    input byte
//   in_valid_i      in   1    input byte valid
//   in_ready_o      out  1    block accepts a byte this cycle
//   out_byte_o      out  8    output byte
//   out_valid_o     out  1    output byte valid
//   out_ready_i     in   1    sink accepts output byte
//   core_start_o    out  1    to core start
//   core_enc_dec_o  out  1    to core enc_dec (latched value)
//   core_data_o     out  64   to core data_i (packed block)
//   core_key_o      out  256  to core key_i (latched key)
//   core_busy_i     in   1    from core busy_o
//   core_ready_i    in   1    from core ready_o
//   core_data_i     in   64   from core data_o
//   busy_o          out  1    1 when state != FILL or a partial block is held
//   error_o         out  1    sticky timeout flag
// BEHAVIOUR
//   Reset (reset=0): state FILL, byte count 0, all registers and outputs 0 (in_ready_o=1 once
//     reset releases; it is 0 while reset is asserted). Reset mid-operation discards everything.
//   FILL: in_ready_o=1. Byte accepted when in_valid_i&in_ready_o. First byte goes to [63:56],
//     eighth to [7:0] (big-endian). Byte 0 also latches enc_dec_i and key_i. After byte 8 -> START
//     next cycle; core_data_o holds the block from then until the next block's first byte.
//   START: core_start_o=1, held until core_busy_i=1 or core_ready_i=1 is sampled, then -> WAIT
//     (core_start_o low from that cycle). If core_ready_i=1 in START, capture as in WAIT.
//   WAIT: core_start_o=0. On core_ready_i=1: capture core_data_i into output shift register -> DRAIN.
//   Timeout: counter cleared on entry to START, increments each cycle in START/WAIT; when it
//     reaches TIMEOUT_CYCLES without core_ready_i: error_o<=1 (sticky until reset), core_start_o=0,
//     block discarded, byte count 0 -> FILL. core_ready_i on the same cycle as timeout wins (capture).
//   DRAIN: out_valid_o=1, out_byte_o=shift[63:56]; on out_valid_o&out_ready_i shift left 8; after
//     8th transfer -> FILL next cycle. out_byte_o stable while out_ready_i=0.
//   in_ready_o=0 in START/WAIT/DRAIN (no overlap of fill and drain). out_valid_o=0 outside DRAIN.
//   core_ready_i outside START/WAIT ignored. enc_dec_i/key_i changes after byte 0 have no effect
//     on the current block.
//   Throughput: 8 fill cycles + 1 + core latency + 8 drain cycles per block, minimum.
// TESTING
//   Bench uses behavioural core model: busy 1 cycle after start, ready with data_o = ~data_i
//     after 40 cycles unless stated.
//   1 Reset: hold reset=0 with random inputs -> all outputs 0; release -> in_ready_o=1, busy_o=0.
//   2 Bytes A5 A5 A5 A5 01 23 45 67, enc_dec_i=1, key DEADBEEF0123...DEADBEEF -> core_data_o=
//     64'hA5A5A5A501234567, core_enc_dec_o=1, key passthrough; out bytes 5A 5A 5A 5A FE DC BA 98.
//   3 Output back-pressure: out_ready_i toggles 1/0 each cycle -> 8 bytes in order, no loss/dup,
//     out_byte_o stable while stalled; in_ready_o=0 until last byte leaves.
//   4 Core never asserts ready (TIMEOUT_CYCLES=16) -> error_o=1 exactly 16 cycles after START
//     entry, return to FILL; next block processes normally, error_o stays 1.
//   5 Reset asserted in WAIT after 20 cycles -> outputs 0 immediately; late core_ready_i ignored.
//   6 Change enc_dec_i to 0 and key after byte 3 -> core_enc_dec_o=1 and original key for block.

Source files
------------

// File: rtl/gost_byte_stream_ctrl_if.sv
// Byte-wide valid/ready link between the stream side and the GOST block controller.
// Carries both the inbound byte stream and the outbound byte stream.
interface gost_byte_stream_ctrl_if;
    logic [7:0] in_byte_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] out_byte_o;
    logic       out_valid_o;
    logic       out_ready_i;

    modport master (
        output in_byte_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_byte_o,
        input  out_valid_o
    );

    modport slave (
        input  in_byte_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output out_byte_o,
        output out_valid_o
    );
endinterface

// File: rtl/gost_byte_stream_ctrl.sv
// Packs 8 bytes into a 64-bit block for the GOST core, waits for the result
// and serialises it back out as 8 bytes, with a sticky timeout on the core.
module gost_byte_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enc_dec_i,
    input  logic [255:0]            key_i,
    gost_byte_stream_ctrl_if.slave  link,
    output logic                    core_start_o,
    output logic                    core_enc_dec_o,
    output logic [63:0]             core_data_o,
    output logic [255:0]            core_key_o,
    input  logic                    core_busy_i,
    input  logic                    core_ready_i,
    input  logic [63:0]             core_data_i,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [TO_W-1:0] to_cnt;
    logic [63:0]     blk_q;
    logic [63:0]     out_q;
    logic            enc_q;
    logic [255:0]    key_q;
    logic            err_q;
    logic            in_fire;
    logic            out_fire;

    // in_ready_o must read 0 while reset is held, not just after the first edge
    assign link.in_ready_o  = reset && (state == S_FILL);
    assign link.out_valid_o = (state == S_DRAIN);
    assign link.out_byte_o  = out_q[63:56];

    assign in_fire  = link.in_valid_i && link.in_ready_o;
    assign out_fire = link.out_valid_o && link.out_ready_i;

    assign core_start_o   = (state == S_START);
    assign core_enc_dec_o = enc_q;
    assign core_data_o    = blk_q;
    assign core_key_o     = key_q;
    assign busy_o         = (state != S_FILL) || (cnt != 3'd0);
    assign error_o        = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_FILL;
            cnt    <= 3'd0;
            to_cnt <= '0;
            blk_q  <= '0;
            out_q  <= '0;
            enc_q  <= 1'b0;
            key_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                S_FILL: begin
                    if (in_fire) begin
                        blk_q <= {blk_q[55:0], link.in_byte_i};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd0) begin
                            enc_q <= enc_dec_i;
                            key_q <= key_i;
                        end
                        if (cnt == 3'd7) begin
                            state  <= S_START;
                            to_cnt <= '0;
                        end
                    end
                end
                S_START, S_WAIT: begin
                    // a result arriving on the timeout cycle still wins
                    if (core_ready_i) begin
                        out_q <= core_data_i;
                        state <= S_DRAIN;
                    end else if (to_cnt == TO_LAST) begin
                        err_q <= 1'b1;
                        state <= S_FILL;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if (state == S_START && core_busy_i)
                            state <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        out_q <= {out_q[55:0], 8'h00};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7)
                            state <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_gost_byte_stream_ctrl.sv
// Scoreboard bench for gost_byte_stream_ctrl with behavioural GOST core models.
// A second instance with a 16-cycle timeout exercises the timeout path.
`timescale 1ns/1ps
module tb_gost_byte_stream_ctrl;

    typedef struct packed {
        logic         enc;
        logic [255:0] key;
        logic [63:0]  data;
    } blk_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic         enc_dec   = 1'b0;
    logic [255:0] key       = '0;
    logic [7:0]   in_byte   = '0;
    logic         in_valid  = 1'b0;
    logic         sel_t     = 1'b0;
    logic         ready_lvl = 1'b0;
    logic         tog       = 1'b0;
    logic         tog_ph    = 1'b0;
    logic         out_ready;
    assign out_ready = tog ? tog_ph : ready_lvl;

    always @(posedge clock) begin
        #1 tog_ph = ~tog_ph;
    end

    gost_byte_stream_ctrl_if l ();
    gost_byte_stream_ctrl_if lt ();

    assign l.in_byte_i   = in_byte;
    assign l.in_valid_i  = in_valid && !sel_t;
    assign l.out_ready_i = out_ready;
    assign lt.in_byte_i   = in_byte;
    assign lt.in_valid_i  = in_valid && sel_t;
    assign lt.out_ready_i = out_ready;

    logic         c_start, c_enc, busy, err;
    logic [63:0]  c_data;
    logic [255:0] c_key;
    logic         c_busy = 1'b0;
    logic         c_ready = 1'b0;
    logic [63:0]  c_dout = '0;

    logic         t_start, t_enc, t_busyo, t_err;
    logic [63:0]  t_data;
    logic [255:0] t_key;
    logic         t_busy = 1'b0;
    logic         t_ready = 1'b0;
    logic [63:0]  t_dout = '0;

    gost_byte_stream_ctrl dut (
        .clock(clock), .reset(reset),
        .enc_dec_i(enc_dec), .key_i(key), .link(l),
        .core_start_o(c_start), .core_enc_dec_o(c_enc),
        .core_data_o(c_data), .core_key_o(c_key),
        .core_busy_i(c_busy), .core_ready_i(c_ready),
        .core_data_i(c_dout), .busy_o(busy), .error_o(err)
    );

    gost_byte_stream_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut_t (
        .clock(clock), .reset(reset),
        .enc_dec_i(enc_dec), .key_i(key), .link(lt),
        .core_start_o(t_start), .core_enc_dec_o(t_enc),
        .core_data_o(t_data), .core_key_o(t_key),
        .core_busy_i(t_busy), .core_ready_i(t_ready),
        .core_data_i(t_dout), .busy_o(t_busyo), .error_o(t_err)
    );

    // main core model: busy after start, ready with ~data about 40 cycles later
    logic        rnd = 1'b1;
    logic        cm_run = 1'b0;
    int          cm_cnt = 0;
    logic [63:0] cm_blk = '0;
    always @(posedge clock) begin
        if (rnd) begin
            c_busy <= 1'($urandom);
            c_ready <= 1'($urandom);
            c_dout <= {$urandom(), $urandom()};
            cm_run <= 1'b0;
        end else begin
            c_ready <= 1'b0;
            if (!cm_run) begin
                c_busy <= 1'b0;
                if (c_start) begin
                    cm_run <= 1'b1;
                    c_busy <= 1'b1;
                    cm_cnt <= 1;
                    cm_blk <= c_data;
                end
            end else if (cm_cnt == 40) begin
                c_ready <= 1'b1;
                c_dout <= ~cm_blk;
                c_busy <= 1'b0;
                cm_run <= 1'b0;
            end else begin
                cm_cnt <= cm_cnt + 1;
            end
        end
    end

    // timeout-instance core model: silent unless t_ok
    logic        t_ok = 1'b0;
    logic        tm_run = 1'b0;
    int          tm_cnt = 0;
    logic [63:0] tm_blk = '0;
    always @(posedge clock) begin
        t_ready <= 1'b0;
        if (!tm_run) begin
            if (t_start && t_ok) begin
                tm_run <= 1'b1;
                t_busy <= 1'b1;
                tm_cnt <= 0;
                tm_blk <= t_data;
            end
        end else if (tm_cnt == 3) begin
            t_ready <= 1'b1;
            t_dout <= ~tm_blk;
            t_busy <= 1'b0;
            tm_run <= 1'b0;
        end else begin
            tm_cnt <= tm_cnt + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string n, input logic [255:0] a,
                         input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    logic [7:0] exp_q[$];
    blk_t       exp_blk[$];

    task automatic pop_cmp(input string n, input logic [7:0] b);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0h expected no byte", n, b);
        end else begin
            check(n, b, exp_q.pop_front());
        end
    endtask

    task automatic blk_cmp(input string n, input logic e,
                           input logic [255:0] k, input logic [63:0] d);
        blk_t b;
        if (exp_blk.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0h expected no block", n, d);
        end else begin
            b = exp_blk.pop_front();
            check({n, "_data"}, d, b.data);
            check({n, "_enc"}, e, b.enc);
            check({n, "_key"}, k, b.key);
        end
    endtask

    logic c_prev = 1'b0;
    logic t_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (l.out_valid_o && l.out_ready_i)
                pop_cmp("out_byte", l.out_byte_o);
            if (l.out_valid_o && !l.out_ready_i && exp_q.size() != 0)
                check("stall_byte", l.out_byte_o, exp_q[0]);
            if (l.out_valid_o)
                check("in_ready_drain", l.in_ready_o, 1'b0);
            if (lt.out_valid_o && lt.out_ready_i)
                pop_cmp("out_byte_t", lt.out_byte_o);
            if (c_start && !c_prev)
                blk_cmp("core", c_enc, c_key, c_data);
            if (t_start && !t_prev)
                blk_cmp("core_t", t_enc, t_key, t_data);
        end
        c_prev = c_start;
        t_prev = t_start;
    end

    task automatic send(input logic [63:0] blk, input logic e,
                        input logic [255:0] k, input bit t,
                        input bit exp_out, input int chg);
        logic [63:0] inv;
        inv = ~blk;
        exp_blk.push_back({e, k, blk});
        if (exp_out)
            for (int i = 0; i < 8; i++)
                exp_q.push_back(inv[63-8*i -: 8]);
        sel_t = t;
        enc_dec = e;
        key = k;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            in_byte = blk[63-8*i -: 8];
            in_valid = 1'b1;
            if (i == chg) begin
                enc_dec = ~e;
                key = ~k;
            end
            @(negedge clock);
            check("in_ready_fill", t ? lt.in_ready_o : l.in_ready_o, 1'b1);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string n);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clock);
            c++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: drain timeout, %0d bytes left, expected 0",
                     n, exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    localparam logic [255:0] KEY0 = {
        32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
        32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978, 32'hDEADBEEF
    };

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            in_byte = 8'($urandom);
            in_valid = 1'($urandom);
            enc_dec = 1'($urandom);
            key = {8{$urandom()}};
            ready_lvl = 1'($urandom);
            @(negedge clock);
            check("rst_in_ready", l.in_ready_o, 1'b0);
            check("rst_out_valid", l.out_valid_o, 1'b0);
            check("rst_out_byte", l.out_byte_o, 8'h00);
            check("rst_start", c_start, 1'b0);
            check("rst_core_data", c_data, 64'h0);
            check("rst_core_key", c_key, 256'h0);
            check("rst_enc", c_enc, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_err", err, 1'b0);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        ready_lvl = 1'b1;
        rnd = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rel_in_ready", l.in_ready_o, 1'b1);
        check("rel_busy", busy, 1'b0);
        check("rel_in_ready_t", lt.in_ready_o, 1'b1);

        // basic block
        send(64'hA5A5A5A501234567, 1'b1, KEY0, 1'b0, 1'b1, 99);
        @(negedge clock);
        check("blk_busy", busy, 1'b1);
        check("blk_key_hold", c_key, KEY0);
        check("blk_data_hold", c_data, 64'hA5A5A5A501234567);
        wait_drain("basic");
        check("basic_idle", busy, 1'b0);
        check("basic_in_ready", l.in_ready_o, 1'b1);

        // output back-pressure
        tog = 1'b1;
        send(64'h0011223344556677, 1'b0, ~KEY0, 1'b0, 1'b1, 99);
        wait_drain("backpressure");
        tog = 1'b0;
        check("bp_in_ready", l.in_ready_o, 1'b1);

        // enc_dec/key change mid-block
        send(64'h1122334455667788, 1'b1, KEY0, 1'b0, 1'b1, 4);
        wait_drain("latch");
        check("latch_err", err, 1'b0);

        // timeout on the 16-cycle instance
        send(64'hCAFEF00D12345678, 1'b1, KEY0, 1'b1, 1'b0, 99);
        @(negedge clock);
        check("to_start", t_start, 1'b1);
        repeat (15) @(negedge clock);
        check("to_err_pre", t_err, 1'b0);
        @(negedge clock);
        check("to_err_at16", t_err, 1'b1);
        check("to_fill", lt.in_ready_o, 1'b1);
        check("to_busy", t_busyo, 1'b0);
        check("to_start_off", t_start, 1'b0);
        t_ok = 1'b1;
        send(64'h0F0F0F0F80000001, 1'b0, KEY0, 1'b1, 1'b1, 99);
        wait_drain("after_timeout");
        check("to_err_sticky", t_err, 1'b1);
        sel_t = 1'b0;

        // reset while waiting for the core
        send(64'h8899AABBCCDDEEFF, 1'b1, KEY0, 1'b0, 1'b0, 99);
        n = 0;
        while (!c_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("wait_busy_seen", c_busy, 1'b1);
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("mid_in_ready", l.in_ready_o, 1'b0);
        check("mid_start", c_start, 1'b0);
        check("mid_data", c_data, 64'h0);
        check("mid_key", c_key, 256'h0);
        check("mid_busy", busy, 1'b0);
        check("mid_valid", l.out_valid_o, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            check("late_ready", {l.out_valid_o, busy}, 2'b00);
        end
        check("late_err", err, 1'b0);
        check("late_in_ready", l.in_ready_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
